// File: rtl/lockin_magnitude_seq.sv
// Magnitude stage behind the lock-in accumulator: floor(sqrt(fase^2 + cuad^2)),
// scaled by a right shift and saturated to 16 bits, using a bit-serial root.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for a pair; in_ready high; operands latched as |x|
// S_SQUARE | form sum of squares, arm the root iteration
// S_SQRT   | one root bit per cycle, MSB first, Q_IN cycles
// S_DONE   | shift, saturate and publish amplitud with an out_valid pulse
module lockin_magnitude_seq #(
  parameter int Q_IN  = 50,
  parameter int SHIFT = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic signed [Q_IN-1:0] fase,
  input  logic signed [Q_IN-1:0] cuad,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [15:0]            amplitud,
  output logic                   out_valid,
  output logic                   saturated,
  output logic                   dropped
);

  localparam int CW = (Q_IN > 1) ? $clog2(Q_IN) : 1;
  localparam int SW = 2 * Q_IN;
  localparam int RW = Q_IN + 2;
  localparam logic [CW-1:0]   CNT_INIT = CW'(Q_IN - 1);
  localparam logic [CW-1:0]   ONE_C    = CW'(1);
  localparam logic [Q_IN-1:0] ONE_Q    = Q_IN'(1);
  localparam logic [Q_IN-1:0] MAX16    = Q_IN'(65535);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SQUARE,
    S_SQRT,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [Q_IN-1:0] abs_f_q, abs_f_d;
  logic [Q_IN-1:0] abs_c_q, abs_c_d;
  logic [SW-1:0]   sum_q, sum_d;
  logic [Q_IN-1:0] root_q, root_d;
  logic [RW-1:0]   rem_q, rem_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [15:0]     amp_q, amp_d;
  logic            sat_q, sat_d;
  logic            ov_q, ov_d;
  logic            drop_q, drop_d;

  // Unsigned negate keeps -2^(Q_IN-1) as exactly 2^(Q_IN-1).
  logic [Q_IN-1:0] fase_u, cuad_u, abs_f_in, abs_c_in;
  assign fase_u   = fase;
  assign cuad_u   = cuad;
  assign abs_f_in = fase_u[Q_IN-1] ? (~fase_u + ONE_Q) : fase_u;
  assign abs_c_in = cuad_u[Q_IN-1] ? (~cuad_u + ONE_Q) : cuad_u;

  logic [SW-1:0] sq_f, sq_c, sq_sum;
  assign sq_f   = {{Q_IN{1'b0}}, abs_f_q} * {{Q_IN{1'b0}}, abs_f_q};
  assign sq_c   = {{Q_IN{1'b0}}, abs_c_q} * {{Q_IN{1'b0}}, abs_c_q};
  assign sq_sum = sq_f + sq_c;

  // Restoring step: remainder before the last shift never exceeds Q_IN bits.
  logic [RW-1:0] rem_sh, trial;
  logic          take;
  assign rem_sh = {rem_q[RW-3:0], sum_q[SW-1 -: 2]};
  assign trial  = {root_q, 2'b01};
  assign take   = (rem_sh >= trial);

  logic [Q_IN-1:0] scaled;
  assign scaled = root_q >> SHIFT;

  always_comb begin
    state_d = state_q;
    abs_f_d = abs_f_q;
    abs_c_d = abs_c_q;
    sum_d   = sum_q;
    root_d  = root_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    amp_d   = amp_q;
    sat_d   = sat_q;
    ov_d    = 1'b0;
    drop_d  = in_valid && (state_q != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          abs_f_d = abs_f_in;
          abs_c_d = abs_c_in;
          state_d = S_SQUARE;
        end
      end
      S_SQUARE: begin
        sum_d   = sq_sum;
        cnt_d   = CNT_INIT;
        root_d  = '0;
        rem_d   = '0;
        state_d = S_SQRT;
      end
      S_SQRT: begin
        sum_d = {sum_q[SW-3:0], 2'b00};
        if (take) begin
          rem_d  = rem_sh - trial;
          root_d = {root_q[Q_IN-2:0], 1'b1};
        end else begin
          rem_d  = rem_sh;
          root_d = {root_q[Q_IN-2:0], 1'b0};
        end
        if (cnt_q == '0) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - ONE_C;
        end
      end
      S_DONE: begin
        if (scaled > MAX16) begin
          amp_d = 16'hFFFF;
          sat_d = 1'b1;
        end else begin
          amp_d = scaled[15:0];
          sat_d = 1'b0;
        end
        ov_d    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      abs_f_q <= '0;
      abs_c_q <= '0;
      sum_q   <= '0;
      root_q  <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      amp_q   <= '0;
      sat_q   <= 1'b0;
      ov_q    <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      abs_f_q <= abs_f_d;
      abs_c_q <= abs_c_d;
      sum_q   <= sum_d;
      root_q  <= root_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      amp_q   <= amp_d;
      sat_q   <= sat_d;
      ov_q    <= ov_d;
      drop_q  <= drop_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign amplitud  = amp_q;
  assign saturated = sat_q;
  assign out_valid = ov_q;
  assign dropped   = drop_q;

endmodule

// File: tb/tb_lockin_magnitude_seq.sv
// Bench for lockin_magnitude_seq: three shift settings driven in lockstep and
// compared against an arithmetic magnitude model.
module tb_lockin_magnitude_seq;

  localparam int Q = 50;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic signed [Q-1:0] fase = '0;
  logic signed [Q-1:0] cuad = '0;
  logic in_valid = 1'b0;

  logic        rdy [3];
  logic [15:0] amp [3];
  logic        ov  [3];
  logic        sat [3];
  logic        drp [3];

  int shifts [3] = '{0, 16, 34};
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lockin_magnitude_seq #(.Q_IN(Q), .SHIFT(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .fase(fase), .cuad(cuad), .in_valid(in_valid),
    .in_ready(rdy[0]), .amplitud(amp[0]), .out_valid(ov[0]), .saturated(sat[0]), .dropped(drp[0]));
  lockin_magnitude_seq #(.Q_IN(Q), .SHIFT(16)) dut16 (
    .clk(clk), .reset_n(reset_n), .fase(fase), .cuad(cuad), .in_valid(in_valid),
    .in_ready(rdy[1]), .amplitud(amp[1]), .out_valid(ov[1]), .saturated(sat[1]), .dropped(drp[1]));
  lockin_magnitude_seq #(.Q_IN(Q), .SHIFT(34)) dut34 (
    .clk(clk), .reset_n(reset_n), .fase(fase), .cuad(cuad), .in_valid(in_valid),
    .in_ready(rdy[2]), .amplitud(amp[2]), .out_valid(ov[2]), .saturated(sat[2]), .dropped(drp[2]));

  // Largest r with r*r <= f^2 + c^2, found by trial squaring.
  function automatic logic [Q-1:0] model_root(input logic signed [Q-1:0] f, input logic signed [Q-1:0] c);
    logic signed [Q:0] fe, ce;
    logic [2*Q-1:0] mf, mc, sum, wide;
    logic [Q-1:0] r, cand;
    fe = f;
    ce = c;
    mf = (fe < 0) ? -fe : fe;
    mc = (ce < 0) ? -ce : ce;
    sum = mf * mf + mc * mc;
    r = '0;
    for (int b = Q - 1; b >= 0; b--) begin
      cand = r | (Q'(1) << b);
      wide = {{Q{1'b0}}, cand};
      if (wide * wide <= sum) r = cand;
    end
    return r;
  endfunction

  task automatic launch(input logic signed [Q-1:0] f, input logic signed [Q-1:0] c);
    fase = f;
    cuad = c;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    fase = $urandom;
    cuad = $urandom;
  endtask

  // Called at the first falling edge after acceptance.
  task automatic collect(input logic signed [Q-1:0] f, input logic signed [Q-1:0] c, input string name,
                         input int drop_at, input bit chain,
                         input logic signed [Q-1:0] nf, input logic signed [Q-1:0] nc);
    logic [Q-1:0] root, sc;
    logic [15:0] e_amp;
    logic e_sat;
    int n, busy_bad, drops;
    bit got;
    root = model_root(f, c);
    n = 0; busy_bad = 0; drops = 0; got = 0;
    for (int j = 1; j <= Q + 20 && !got; j++) begin
      if (drop_at > 0 && j == drop_at) begin
        in_valid = 1'b1;
        fase = $urandom;
        cuad = $urandom;
      end
      if (drop_at > 0 && j == drop_at + 1) in_valid = 1'b0;
      @(negedge clk);
      if (drp[0]) drops++;
      if (ov[0]) begin
        got = 1; n = j;
      end else if (rdy[0] || rdy[1] || rdy[2]) busy_bad++;
    end
    in_valid = 1'b0;
    checks++;
    if (!got || n !== Q + 2) begin
      errors++;
      $display("FAIL %s latency: got %0d edges (seen=%0d), expected %0d", name, n, got, Q + 2);
    end
    checks++;
    if (busy_bad !== 0) begin
      errors++;
      $display("FAIL %s in_ready_busy: high in %0d busy cycles, expected 0", name, busy_bad);
    end
    checks++;
    if (drops !== ((drop_at > 0) ? 1 : 0)) begin
      errors++;
      $display("FAIL %s dropped_count: got %0d, expected %0d", name, drops, (drop_at > 0) ? 1 : 0);
    end
    for (int i = 0; i < 3; i++) begin
      sc = root >> shifts[i];
      e_sat = (sc > Q'(65535));
      e_amp = e_sat ? 16'hFFFF : sc[15:0];
      checks++;
      if (ov[i] !== 1'b1 || amp[i] !== e_amp || sat[i] !== e_sat) begin
        errors++;
        $display("FAIL %s result shift=%0d: amp=%0d sat=%b ov=%b, expected amp=%0d sat=%b ov=1",
                 name, shifts[i], amp[i], sat[i], ov[i], e_amp, e_sat);
      end
    end
    if (chain) begin
      fase = nf;
      cuad = nc;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      fase = $urandom;
      cuad = $urandom;
      checks++;
      if (rdy[0] !== 1'b0 || ov[0] !== 1'b0) begin
        errors++;
        $display("FAIL %s chain_accept: in_ready=%b out_valid=%b, expected 0 0", name, rdy[0], ov[0]);
      end
    end else begin
      @(negedge clk);
      checks++;
      if (ov[0] !== 1'b0 || ov[1] !== 1'b0 || ov[2] !== 1'b0 || rdy[0] !== 1'b1) begin
        errors++;
        $display("FAIL %s pulse_width: out_valid=%b%b%b in_ready=%b, expected 000 1",
                 name, ov[0], ov[1], ov[2], rdy[0]);
      end
    end
  endtask

  task automatic run_one(input logic signed [Q-1:0] f, input logic signed [Q-1:0] c, input string name);
    launch(f, c);
    collect(f, c, name, 0, 1'b0, '0, '0);
  endtask

  task automatic check_reset_outputs(input string name);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (amp[i] !== 16'd0 || ov[i] !== 1'b0 || sat[i] !== 1'b0 || drp[i] !== 1'b0 || rdy[i] !== 1'b1) begin
        errors++;
        $display("FAIL %s outputs inst %0d: amp=%0d ov=%b sat=%b drop=%b rdy=%b, expected 0 0 0 0 1",
                 name, i, amp[i], ov[i], sat[i], drp[i], rdy[i]);
      end
    end
  endtask

  task automatic test_reset;
    #2 reset_n = 1'b0;
    #1 check_reset_outputs("reset");
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    run_one(50'sd3, 50'sd4, "basic_3_4");
  endtask

  task automatic test_signs;
    run_one(-50'sd3, -50'sd4, "neg_3_4");
    run_one(50'sd1, 50'sd1, "one_one");
    run_one(50'sd0, 50'sd0, "zero");
  endtask

  task automatic test_extreme;
    logic signed [Q-1:0] mn;
    mn = {1'b1, {(Q-1){1'b0}}};
    run_one(mn, 50'sd0, "most_negative");
    run_one(mn, mn, "both_most_negative");
    run_one({1'b0, {(Q-1){1'b1}}}, mn, "max_pos_most_neg");
  endtask

  task automatic test_scaled;
    run_one(50'sd3 <<< 20, 50'sd4 <<< 20, "scaled_80");
  endtask

  task automatic test_dropped_back_to_back;
    logic signed [Q-1:0] f1, c1, f2, c2;
    f1 = 50'sd123456789; c1 = -50'sd987654;
    f2 = -50'sd7 <<< 30; c2 = 50'sd24 <<< 30;
    launch(f1, c1);
    collect(f1, c1, "dropped_first", 5, 1'b1, f2, c2);
    collect(f2, c2, "back_to_back", 0, 1'b0, '0, '0);
  endtask

  task automatic test_random;
    logic [63:0] w;
    logic signed [Q-1:0] f, c;
    for (int t = 0; t < 10; t++) begin
      w = {$urandom, $urandom};
      f = w[Q-1:0];
      f = f >>> $urandom_range(0, Q - 1);
      w = {$urandom, $urandom};
      c = w[Q-1:0];
      c = c >>> $urandom_range(0, Q - 1);
      run_one(f, c, $sformatf("random_%0d", t));
    end
  endtask

  task automatic test_reset_mid;
    int stray;
    launch(50'sd5 <<< 40, 50'sd12 <<< 40);
    repeat (9) @(negedge clk);
    #2 reset_n = 1'b0;
    #1 check_reset_outputs("reset_mid");
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    stray = 0;
    repeat (Q + 10) begin
      @(negedge clk);
      if (ov[0] || ov[1] || ov[2]) stray++;
    end
    checks++;
    if (stray !== 0) begin
      errors++;
      $display("FAIL reset_mid stray_out_valid: got %0d pulses, expected 0", stray);
    end
    run_one(-50'sd8 <<< 25, 50'sd15 <<< 25, "after_reset");
  endtask

  initial begin
    test_reset;
    test_basic;
    test_signs;
    test_extreme;
    test_scaled;
    test_dropped_back_to_back;
    test_random;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
